// File: rtl/fp_pkg.sv
// Shared types and constants for the FP datapath.
//   fp32_t       : packed IEEE-754 single {sign, exp, frac}
//   div_state_e  : divider FSM states
//   fp_class_e   : operand classification produced by fp_classify
//   QNAN/POS_INF : canonical special results (single precision)
package fp_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVIDE,
        S_NORM,
        S_DONE
    } div_state_e;

    typedef enum logic [2:0] {
        FP_ZERO,
        FP_DENORM,
        FP_NORMAL,
        FP_INF,
        FP_NAN
    } fp_class_e;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier.
//   exp, frac : exponent and stored fraction fields of one operand
//   is_zero   : exponent and fraction both zero
//   is_denorm : exponent zero, fraction non-zero
//   is_inf    : exponent all ones, fraction zero
//   is_nan    : exponent all ones, fraction non-zero
module fp_classify
    import fp_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int FRAC_W = FP_FRAC_W
) (
    input  logic [EXP_W-1:0]  exp,
    input  logic [FRAC_W-1:0] frac,
    output logic              is_zero,
    output logic              is_denorm,
    output logic              is_inf,
    output logic              is_nan
);

    fp_class_e cls;

    always_comb begin
        cls = FP_NORMAL;
        if (exp == '0)
            cls = (frac == '0) ? FP_ZERO : FP_DENORM;
        else if (exp == '1)
            cls = (frac == '0) ? FP_INF : FP_NAN;
    end

    assign is_zero   = (cls == FP_ZERO);
    assign is_denorm = (cls == FP_DENORM);
    assign is_inf    = (cls == FP_INF);
    assign is_nan    = (cls == FP_NAN);

endmodule

// File: rtl/fp_divider.sv
// Sequential IEEE-754 divider, quotient = dividend / divisor.
// Radix-2 restoring mantissa division, one quotient bit per clock,
// truncating rounding, denormals flushed to zero.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : operand handshake (ready only when idle)
//   dividend, divisor     : IEEE operands
//   out_valid/out_ready   : result handshake
//   quotient, div_by_zero : result and x/0 flag, qualified by out_valid
module fp_divider
    import fp_pkg::*;
#(
    parameter int EXP_W  = FP_EXP_W,
    parameter int FRAC_W = FP_FRAC_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXP_W+FRAC_W:0]     dividend,
    input  logic [EXP_W+FRAC_W:0]     divisor,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     quotient,
    output logic                      div_by_zero
);

    localparam int W    = 1 + EXP_W + FRAC_W;
    localparam int MW   = FRAC_W + 1;          // mantissa incl. hidden 1
    localparam int RW   = MW + 2;              // remainder, headroom for the shift
    localparam int EW   = EXP_W + 2;           // signed exponent difference
    localparam int BIAS = 2**(EXP_W-1) - 1;
    localparam int CW   = $clog2(MW + 1);
    localparam logic [CW-1:0]        LAST    = CW'(MW);  // MW+1 quotient bits
    localparam logic signed [EW-1:0] EXP_MAX = EW'(2**EXP_W - 1);

    localparam logic [W-2:0] INF_MAG  = {{EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    localparam logic [W-1:0] QNAN_VAL = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    // operand fields
    logic              sa, sb;
    logic [EXP_W-1:0]  ea, eb;
    logic [FRAC_W-1:0] fa, fb;

    assign {sa, ea, fa} = dividend;
    assign {sb, eb, fb} = divisor;

    logic a_zero, a_den, a_inf, a_nan;
    logic b_zero, b_den, b_inf, b_nan;

    fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_a (
        .exp(ea), .frac(fa),
        .is_zero(a_zero), .is_denorm(a_den), .is_inf(a_inf), .is_nan(a_nan)
    );

    fp_classify #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) u_cls_b (
        .exp(eb), .frac(fb),
        .is_zero(b_zero), .is_denorm(b_den), .is_inf(b_inf), .is_nan(b_nan)
    );

    // denormals behave exactly like zero
    logic a_z, b_z, sign_in;
    assign a_z     = a_zero | a_den;
    assign b_z     = b_zero | b_den;
    assign sign_in = sa ^ sb;

    logic         special, special_dbz;
    logic [W-1:0] special_res;

    always_comb begin
        special     = 1'b1;
        special_dbz = 1'b0;
        special_res = {sign_in, {(W-1){1'b0}}};
        if (a_nan || b_nan || (a_z && b_z) || (a_inf && b_inf))
            special_res = QNAN_VAL;
        else if (a_inf)
            special_res = {sign_in, INF_MAG};
        else if (b_z) begin
            special_res = {sign_in, INF_MAG};
            special_dbz = 1'b1;
        end else if (a_z || b_inf)
            special_res = {sign_in, {(W-1){1'b0}}};
        else
            special = 1'b0;
    end

    logic signed [EW-1:0] exp_in;
    assign exp_in = EW'({2'b00, ea}) - EW'({2'b00, eb}) + EW'(BIAS);

    // state and datapath registers
    div_state_e           state, state_nxt;
    logic                 sign;
    logic signed [EW-1:0] exp_diff;
    logic [RW-1:0]        rem;
    logic [MW-1:0]        mb;
    logic [MW:0]          q;
    logic [CW-1:0]        cnt;

    // one restoring step
    logic [RW-1:0] rem_sub, rem_keep;
    logic          rem_ge;
    assign rem_ge   = (rem >= {2'b00, mb});
    assign rem_sub  = rem - {2'b00, mb};
    assign rem_keep = rem_ge ? rem_sub : rem;

    // normalisation: q is in [2^(MW-1), 2^(MW+1)) since both mantissas are in [1,2)
    logic signed [EW-1:0] exp_n;
    logic [FRAC_W-1:0]    frac_n;
    assign exp_n  = q[MW] ? exp_diff : exp_diff - EW'(1);
    assign frac_n = q[MW] ? q[MW-1:1] : q[MW-2:0];

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (in_valid) state_nxt = special ? S_DONE : S_DIVIDE;
            S_DIVIDE: if (cnt == LAST) state_nxt = S_NORM;
            S_NORM:   state_nxt = S_DONE;
            S_DONE:   if (out_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign        <= 1'b0;
            exp_diff    <= '0;
            rem         <= '0;
            mb          <= '0;
            q           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    sign     <= sign_in;
                    exp_diff <= exp_in;
                    rem      <= {2'b00, 1'b1, fa};
                    mb       <= {1'b1, fb};
                    q        <= '0;
                    cnt      <= '0;
                    if (special) begin
                        quotient    <= special_res;
                        div_by_zero <= special_dbz;
                    end
                end
                S_DIVIDE: begin
                    q   <= {q[MW-1:0], rem_ge};
                    rem <= {rem_keep[RW-2:0], 1'b0};
                    cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
                end
                S_NORM: begin
                    div_by_zero <= 1'b0;
                    if (exp_n >= EXP_MAX)
                        quotient <= {sign, INF_MAG};
                    else if (exp_n[EW-1] || exp_n == '0)
                        quotient <= {sign, {(W-1){1'b0}}};
                    else
                        quotient <= {sign, exp_n[EXP_W-1:0], frac_n};
                end
                default: ;
            endcase
        end
    end

endmodule
